// File: rtl/branch_resolve_unit_if.sv
// Prediction push, resolve, redirect and training signals between fetch/execute
// and the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int DEPTH    = 4,
  parameter int wordSize = 32
);
  logic                       predValid;
  logic [wordSize-1:0]        predPc;
  logic                       predTaken;
  logic [wordSize-1:0]        predTarget;
  logic                       predReady;
  logic                       resValid;
  logic                       resTaken;
  logic [wordSize-1:0]        resTarget;
  logic                       redirectValid;
  logic [wordSize-1:0]        redirectPc;
  logic                       updValid;
  logic [wordSize-1:0]        updPc;
  logic                       updTaken;
  logic [$clog2(DEPTH):0]     inflight;
  logic [15:0]                mispredictCount;
  logic                       resErr;

  modport master (
    output predValid, predPc, predTaken, predTarget, resValid, resTaken, resTarget,
    input  predReady, redirectValid, redirectPc, updValid, updPc, updTaken,
           inflight, mispredictCount, resErr
  );

  modport slave (
    input  predValid, predPc, predTaken, predTarget, resValid, resTaken, resTarget,
    output predReady, redirectValid, redirectPc, updValid, updPc, updTaken,
           inflight, mispredictCount, resErr
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of branch predictions; resolves the oldest against execute,
// flushing and redirecting on mispredict and emitting a training update.
module branch_resolve_unit #(
  parameter int DEPTH    = 4,
  parameter int wordSize = 32
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [wordSize-1:0] pc;
    logic                taken;
    logic [wordSize-1:0] target;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;
  entry_t            head_e;
  logic              push, resolve, mispredict;

  assign head_e        = mem[head];
  assign bus.predReady = (count < (PW+1)'(DEPTH));
  assign bus.inflight  = count;

  assign push       = bus.predValid && bus.predReady;
  assign resolve    = bus.resValid && (count != '0);
  assign mispredict = resolve && ((bus.resTaken != head_e.taken) ||
                                  (bus.resTaken && (bus.resTarget != head_e.target)));

  // A push in the same cycle as a mispredict is wrong-path and never lands.
  always_ff @(posedge clk) begin
    if (push && !mispredict)
      mem[tail] <= '{pc: bus.predPc, taken: bus.predTaken, target: bus.predTarget};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      bus.redirectValid   <= 1'b0;
      bus.redirectPc      <= '0;
      bus.updValid        <= 1'b0;
      bus.updPc           <= '0;
      bus.updTaken        <= 1'b0;
      bus.mispredictCount <= '0;
      bus.resErr          <= 1'b0;
    end else begin
      bus.updValid      <= resolve;
      bus.redirectValid <= mispredict;
      if (resolve) begin
        bus.updPc    <= head_e.pc;
        bus.updTaken <= bus.resTaken;
      end
      if (mispredict) begin
        bus.redirectPc <= bus.resTaken ? bus.resTarget : head_e.pc + wordSize'(4);
        if (bus.mispredictCount != 16'hFFFF)
          bus.mispredictCount <= bus.mispredictCount + 16'd1;
      end
      if (bus.resValid && (count == '0))
        bus.resErr <= 1'b1;

      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push)    tail <= tail + PW'(1);
        if (resolve) head <= head + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(resolve);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: flush, redirect, wrap, error and saturation.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DEPTH(4), .wordSize(32)) bif ();

  branch_resolve_unit #(.DEPTH(4), .wordSize(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.predValid  = 1'b0;
    bif.predPc     = '0;
    bif.predTaken  = 1'b0;
    bif.predTarget = '0;
    bif.resValid   = 1'b0;
    bif.resTaken   = 1'b0;
    bif.resTarget  = '0;
  endtask

  task automatic set_pred(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bif.predValid  = 1'b1;
    bif.predPc     = pc;
    bif.predTaken  = tk;
    bif.predTarget = tgt;
  endtask

  task automatic set_res(input logic tk, input logic [31:0] tgt);
    bif.resValid  = 1'b1;
    bif.resTaken  = tk;
    bif.resTarget = tgt;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    set_pred(pc, tk, tgt);
    cyc();
    idle();
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    set_res(tk, tgt);
    cyc();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++; if (bif.predReady !== 1'b1) begin errors++; $display("FAIL reset_predReady got %b exp 1", bif.predReady); end
    checks++; if (bif.inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", bif.inflight); end
    checks++; if (bif.redirectValid !== 1'b0) begin errors++; $display("FAIL reset_redirectValid got %b exp 0", bif.redirectValid); end
    checks++; if (bif.updValid !== 1'b0) begin errors++; $display("FAIL reset_updValid got %b exp 0", bif.updValid); end
    checks++; if (bif.mispredictCount !== 16'd0) begin errors++; $display("FAIL reset_count got %h exp 0", bif.mispredictCount); end
    checks++; if (bif.resErr !== 1'b0) begin errors++; $display("FAIL reset_resErr got %b exp 0", bif.resErr); end
  endtask

  task automatic test_correct();
    push(32'h100, 1'b1, 32'h200);
    checks++; if (bif.inflight !== 3'd1) begin errors++; $display("FAIL correct_inflight1 got %0d exp 1", bif.inflight); end
    resolve(1'b1, 32'h200);
    checks++; if (bif.updValid !== 1'b1) begin errors++; $display("FAIL correct_updValid got %b exp 1", bif.updValid); end
    checks++; if (bif.updPc !== 32'h100) begin errors++; $display("FAIL correct_updPc got %h exp 100", bif.updPc); end
    checks++; if (bif.updTaken !== 1'b1) begin errors++; $display("FAIL correct_updTaken got %b exp 1", bif.updTaken); end
    checks++; if (bif.redirectValid !== 1'b0) begin errors++; $display("FAIL correct_redirectValid got %b exp 0", bif.redirectValid); end
    checks++; if (bif.inflight !== 3'd0) begin errors++; $display("FAIL correct_inflight got %0d exp 0", bif.inflight); end
    cyc();
    checks++; if (bif.updValid !== 1'b0) begin errors++; $display("FAIL correct_updPulse got %b exp 0", bif.updValid); end
    checks++; if (bif.updPc !== 32'h100) begin errors++; $display("FAIL correct_updPcHold got %h exp 100", bif.updPc); end
  endtask

  task automatic test_mispredict_flush();
    push(32'h100, 1'b0, 32'h0);
    push(32'h110, 1'b0, 32'h0);
    push(32'h120, 1'b0, 32'h0);
    checks++; if (bif.inflight !== 3'd3) begin errors++; $display("FAIL flush_inflight3 got %0d exp 3", bif.inflight); end
    set_pred(32'h130, 1'b0, 32'h0);
    set_res(1'b1, 32'h300);
    cyc();
    idle();
    checks++; if (bif.redirectValid !== 1'b1) begin errors++; $display("FAIL flush_redirectValid got %b exp 1", bif.redirectValid); end
    checks++; if (bif.redirectPc !== 32'h300) begin errors++; $display("FAIL flush_redirectPc got %h exp 300", bif.redirectPc); end
    checks++; if (bif.inflight !== 3'd0) begin errors++; $display("FAIL flush_inflight got %0d exp 0", bif.inflight); end
    checks++; if (bif.mispredictCount !== 16'd1) begin errors++; $display("FAIL flush_count got %0d exp 1", bif.mispredictCount); end
    checks++; if (bif.updPc !== 32'h100 || bif.updTaken !== 1'b1) begin errors++; $display("FAIL flush_upd got %h/%b exp 100/1", bif.updPc, bif.updTaken); end
    // next entry through must be a fresh push, not the dropped 0x130
    push(32'h140, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    checks++; if (bif.updPc !== 32'h140) begin errors++; $display("FAIL flush_dropped got %h exp 140", bif.updPc); end
    checks++; if (bif.redirectValid !== 1'b0) begin errors++; $display("FAIL flush_noRedirect got %b exp 0", bif.redirectValid); end
  endtask

  task automatic test_fallthrough_wrap();
    push(32'hFFFF_FFFC, 1'b1, 32'h40);
    resolve(1'b0, 32'h0);
    checks++; if (bif.redirectValid !== 1'b1) begin errors++; $display("FAIL fall_redirectValid got %b exp 1", bif.redirectValid); end
    checks++; if (bif.redirectPc !== 32'h0) begin errors++; $display("FAIL fall_redirectPc got %h exp 0", bif.redirectPc); end
    checks++; if (bif.mispredictCount !== 16'd2) begin errors++; $display("FAIL fall_count got %0d exp 2", bif.mispredictCount); end
    push(32'h100, 1'b1, 32'h200);
    resolve(1'b1, 32'h204);
    checks++; if (bif.redirectValid !== 1'b1) begin errors++; $display("FAIL tgt_redirectValid got %b exp 1", bif.redirectValid); end
    checks++; if (bif.redirectPc !== 32'h204) begin errors++; $display("FAIL tgt_redirectPc got %h exp 204", bif.redirectPc); end
    checks++; if (bif.mispredictCount !== 16'd3) begin errors++; $display("FAIL tgt_count got %0d exp 3", bif.mispredictCount); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    checks++; if (bif.predReady !== 1'b0) begin errors++; $display("FAIL full_predReady got %b exp 0", bif.predReady); end
    checks++; if (bif.inflight !== 3'd4) begin errors++; $display("FAIL full_inflight got %0d exp 4", bif.inflight); end
    set_pred(32'h1010, 1'b0, 32'h0);
    set_res(1'b0, 32'h0);
    cyc();
    checks++; if (bif.inflight !== 3'd3) begin errors++; $display("FAIL full_refused got %0d exp 3", bif.inflight); end
    checks++; if (bif.updPc !== 32'h1000) begin errors++; $display("FAIL full_updPc0 got %h exp 1000", bif.updPc); end
    for (int i = 0; i < 6; i++) begin
      set_pred(32'h1010 + 32'(i * 4), 1'b0, 32'h0);
      set_res(1'b0, 32'h0);
      cyc();
      checks++; if (bif.updPc !== 32'h1004 + 32'(i * 4) || bif.updValid !== 1'b1) begin
        errors++; $display("FAIL wrap_updPc[%0d] got %h exp %h", i, bif.updPc, 32'h1004 + 32'(i * 4));
      end
      checks++; if (bif.inflight !== 3'd3) begin errors++; $display("FAIL wrap_inflight[%0d] got %0d exp 3", i, bif.inflight); end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      resolve(1'b0, 32'h0);
      checks++; if (bif.updPc !== 32'h101C + 32'(i * 4)) begin errors++; $display("FAIL drain_updPc[%0d] got %h exp %h", i, bif.updPc, 32'h101C + 32'(i * 4)); end
    end
    checks++; if (bif.inflight !== 3'd0 || bif.mispredictCount !== 16'd3) begin
      errors++; $display("FAIL drain_state got %0d/%0d exp 0/3", bif.inflight, bif.mispredictCount);
    end
  endtask

  task automatic test_error();
    resolve(1'b1, 32'h500);
    checks++; if (bif.resErr !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", bif.resErr); end
    checks++; if (bif.updValid !== 1'b0 || bif.redirectValid !== 1'b0) begin
      errors++; $display("FAIL err_noOut got %b/%b exp 0/0", bif.updValid, bif.redirectValid);
    end
    checks++; if (bif.inflight !== 3'd0 || bif.mispredictCount !== 16'd3) begin
      errors++; $display("FAIL err_state got %0d/%0d exp 0/3", bif.inflight, bif.mispredictCount);
    end
    cyc(); cyc();
    checks++; if (bif.resErr !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bif.resErr); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65537; i++) begin
      push(32'h2000, 1'b0, 32'h0);
      resolve(1'b1, 32'h3000);
    end
    checks++; if (bif.mispredictCount !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %h exp ffff", bif.mispredictCount); end
    checks++; if (bif.redirectPc !== 32'h3000 || bif.resErr !== 1'b1) begin
      errors++; $display("FAIL sat_misc got %h/%b exp 3000/1", bif.redirectPc, bif.resErr);
    end
  endtask

  task automatic test_reset_midflight();
    push(32'h700, 1'b0, 32'h0);
    push(32'h704, 1'b0, 32'h0);
    set_res(1'b1, 32'h900);
    rst = 1'b1;
    cyc();
    idle();
    rst = 1'b0;
    checks++; if (bif.inflight !== 3'd0 || bif.predReady !== 1'b1) begin
      errors++; $display("FAIL rstmid_queue got %0d/%b exp 0/1", bif.inflight, bif.predReady);
    end
    checks++; if (bif.updValid !== 1'b0 || bif.redirectValid !== 1'b0 || bif.redirectPc !== 32'h0) begin
      errors++; $display("FAIL rstmid_out got %b/%b/%h exp 0/0/0", bif.updValid, bif.redirectValid, bif.redirectPc);
    end
    checks++; if (bif.resErr !== 1'b0 || bif.mispredictCount !== 16'd0) begin
      errors++; $display("FAIL rstmid_state got %b/%h exp 0/0", bif.resErr, bif.mispredictCount);
    end
    cyc();
    checks++; if (bif.updValid !== 1'b0 || bif.redirectValid !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet got %b/%b exp 0/0", bif.updValid, bif.redirectValid);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_correct();
    test_mispredict_flush();
    test_fallthrough_wrap();
    test_full_wrap();
    test_error();
    test_saturation();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
